// File: rtl/reg_sel_seq.sv
// Register-select sequencer: turns operand fields, microsequencer indices or a
// register-list walk into registered one-hot output-enable and load strobes.
module reg_sel_seq #(
    parameter int NREGS = 8,
    parameter int NOPS  = 3,
    localparam int SELW = $clog2(NREGS),
    localparam int SSW  = $clog2(NOPS + 1)
) (
    input  logic                   clock,
    input  logic                   notReset,
    input  logic                   irLoad,
    input  logic [NOPS*SELW-1:0]   opFields,
    input  logic                   oe,
    input  logic                   load,
    input  logic [SSW-1:0]         oeSourceSel,
    input  logic                   loadSourceSel,
    input  logic [SELW-1:0]        useqRegSelOe,
    input  logic [SELW-1:0]        useqRegSelLoad,
    input  logic                   listStart,
    input  logic [NREGS-1:0]       listMask,
    input  logic                   listDir,
    input  logic                   listStep,
    output logic [NREGS-1:0]       regOes,
    output logic [NREGS-1:0]       regLoads,
    output logic                   listBusy,
    output logic [SELW-1:0]        listCur,
    output logic                   listDone,
    output logic                   sameReg
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [NREGS-1:0] pending_q, pending_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic [SELW-1:0]  field_q [NOPS];
    logic [NREGS-1:0] oes_q, oes_d;
    logic [NREGS-1:0] loads_q, loads_d;
    logic             same_q, same_d;

    logic [SELW-1:0]  walk_sel;
    logic [SELW-1:0]  oe_idx;
    logic             oe_valid;
    logic [SELW-1:0]  load_idx;

    // Priority encode the pending set: lowest bit ascending, highest descending.
    always_comb begin
        walk_sel = '0;
        if (dir_q) begin
            for (int i = 0; i < NREGS; i++)
                if (pending_q[i]) walk_sel = SELW'(i);
        end else begin
            for (int i = NREGS - 1; i >= 0; i--)
                if (pending_q[i]) walk_sel = SELW'(i);
        end
    end

    assign listBusy = (state_q == RUN);
    assign listCur  = listBusy ? walk_sel : '0;

    // Strobe selection uses the pre-step listCur and previously latched fields.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        oe_idx   = listBusy ? listCur : useqRegSelOe;
        oe_valid = (oeSourceSel == '0);
        for (int k = 1; k <= NOPS; k++) begin
            if (int'(oeSourceSel) == k) begin
                oe_idx   = field_q[k-1];
                oe_valid = 1'b1;
            end
        end
        load_idx = loadSourceSel ? field_q[0]
                                 : (listBusy ? listCur : useqRegSelLoad);

        oes_d   = (oe && oe_valid) ? (NREGS'(1) << oe_idx) : '0;
        loads_d = load ? (NREGS'(1) << load_idx) : '0;
        same_d  = (oes_d != '0) && (oes_d == loads_d);
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (listStart) begin
                    if (listMask != '0) begin
                        pending_d = listMask;
                        dir_d     = listDir;
                        state_d   = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (listStep) begin
                    pending_d = pending_q & ~(NREGS'(1) << walk_sel);
                    if (pending_d == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            dir_q     <= 1'b0;
            done_q    <= 1'b0;
            oes_q     <= '0;
            loads_q   <= '0;
            same_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dir_q     <= dir_d;
            done_q    <= done_d;
            oes_q     <= oes_d;
            loads_q   <= loads_d;
            same_q    <= same_d;
        end
    end

    // NOTE: the field array is small and must read as zero after reset, so it
    // is reset explicitly rather than treated as an uninitialised memory.
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            for (int k = 0; k < NOPS; k++) field_q[k] <= '0;
        end else if (irLoad) begin
            for (int k = 0; k < NOPS; k++) field_q[k] <= opFields[k*SELW +: SELW];
        end
    end

    assign regOes   = oes_q;
    assign regLoads = loads_q;
    assign sameReg  = same_q;
    assign listDone = done_q;

endmodule

// File: tb/tb_reg_sel_seq.sv
// Scoreboard bench for reg_sel_seq (NREGS=8, NOPS=3): expected outputs are
// queued when a cycle's stimulus is driven and compared after the edge.
module tb_reg_sel_seq;

    logic       clock = 1'b0;
    logic       notReset;
    logic       irLoad;
    logic [8:0] opFields;
    logic       oe, load;
    logic [1:0] oeSourceSel;
    logic       loadSourceSel;
    logic [2:0] useqRegSelOe, useqRegSelLoad;
    logic       listStart;
    logic [7:0] listMask;
    logic       listDir, listStep;
    logic [7:0] regOes, regLoads;
    logic       listBusy;
    logic [2:0] listCur;
    logic       listDone, sameReg;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      tag;
        logic [7:0] oes;
        logic [7:0] loads;
        logic       same;
        logic       busy;
        logic [2:0] cur;
        logic       done;
    } exp_t;

    exp_t sb_q[$];

    reg_sel_seq #(.NREGS(8), .NOPS(3)) dut (
        .clock(clock), .notReset(notReset), .irLoad(irLoad), .opFields(opFields),
        .oe(oe), .load(load), .oeSourceSel(oeSourceSel), .loadSourceSel(loadSourceSel),
        .useqRegSelOe(useqRegSelOe), .useqRegSelLoad(useqRegSelLoad),
        .listStart(listStart), .listMask(listMask), .listDir(listDir), .listStep(listStep),
        .regOes(regOes), .regLoads(regLoads), .listBusy(listBusy), .listCur(listCur),
        .listDone(listDone), .sameReg(sameReg)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input exp_t e);
        check({e.tag, ".regOes"},   32'(regOes),   32'(e.oes));
        check({e.tag, ".regLoads"}, 32'(regLoads), 32'(e.loads));
        check({e.tag, ".sameReg"},  32'(sameReg),  32'(e.same));
        check({e.tag, ".listBusy"}, 32'(listBusy), 32'(e.busy));
        check({e.tag, ".listCur"},  32'(listCur),  32'(e.cur));
        check({e.tag, ".listDone"}, 32'(listDone), 32'(e.done));
    endtask

    task automatic idle_inputs();
        irLoad = 0; opFields = '0; oe = 0; load = 0; oeSourceSel = '0;
        loadSourceSel = 0; useqRegSelOe = '0; useqRegSelLoad = '0;
        listStart = 0; listMask = '0; listDir = 0; listStep = 0;
    endtask

    // Inputs are already driven; queue the expectation, clock once, compare.
    task automatic step(input string tag, input logic [7:0] oes, input logic [7:0] loads,
                        input logic same, input logic busy, input logic [2:0] cur,
                        input logic done);
        exp_t e;
        e = '{tag, oes, loads, same, busy, cur, done};
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_all(e);
        end
        @(negedge clock);
        idle_inputs();
    endtask

    initial begin
        exp_t z;
        idle_inputs();
        notReset = 0;
        #12;
        z = '{"reset", 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0};
        check_all(z);
        @(negedge clock);
        notReset = 1;

        // Fields latch this edge; selection still sees the reset (zero) fields.
        irLoad = 1; opFields = {3'd2, 3'd5, 3'd7}; oe = 1; oeSourceSel = 2'd2;
        step("ir_same_cycle", 8'h01, 8'h00, 0, 0, 3'd0, 0);
        oe = 1; oeSourceSel = 2'd2;
        step("op1_oe", 8'h20, 8'h00, 0, 0, 3'd0, 0);
        oe = 1; oeSourceSel = 2'd1; load = 1; loadSourceSel = 1;
        step("op0_same", 8'h80, 8'h80, 1, 0, 3'd0, 0);
        oe = 1; oeSourceSel = 2'd3; load = 1; useqRegSelLoad = 3'd2;
        step("op2_vs_useq", 8'h04, 8'h04, 1, 0, 3'd0, 0);
        load = 1; useqRegSelLoad = 3'd5; useqRegSelOe = 3'd1;
        step("oe_off", 8'h00, 8'h20, 0, 0, 3'd0, 0);
        oe = 1; useqRegSelOe = 3'd6; load = 1; useqRegSelLoad = 3'd3;
        step("useq_diff", 8'h40, 8'h08, 0, 0, 3'd0, 0);

        // Ascending walk; start and step together in IDLE: start wins.
        listStart = 1; listMask = 8'b1001_0010; listDir = 0; listStep = 1;
        oe = 1; useqRegSelOe = 3'd3;
        step("asc_start", 8'h08, 8'h00, 0, 1, 3'd1, 0);
        listStep = 1; oe = 1;
        step("asc_1", 8'h02, 8'h00, 0, 1, 3'd4, 0);
        listStep = 1; oe = 1; listStart = 1; listMask = 8'hff;
        step("asc_4", 8'h10, 8'h00, 0, 1, 3'd7, 0);
        listStep = 1; oe = 1; load = 1;
        step("asc_7_done", 8'h80, 8'h80, 1, 0, 3'd0, 1);
        oe = 1; useqRegSelOe = 3'd3;
        step("asc_after", 8'h08, 8'h00, 0, 0, 3'd0, 0);

        // Descending walk with a listStart mid-RUN that must be ignored.
        listStart = 1; listMask = 8'b1001_0010; listDir = 1;
        step("dsc_start", 8'h00, 8'h00, 0, 1, 3'd7, 0);
        listStep = 1; oe = 1;
        step("dsc_7", 8'h80, 8'h00, 0, 1, 3'd4, 0);
        listStart = 1; listMask = 8'h01; listDir = 0; oe = 1;
        step("dsc_start_ignored", 8'h10, 8'h00, 0, 1, 3'd4, 0);
        listStep = 1; oe = 1;
        step("dsc_4", 8'h10, 8'h00, 0, 1, 3'd1, 0);
        listStep = 1; oe = 1;
        step("dsc_1_done", 8'h02, 8'h00, 0, 0, 3'd0, 1);
        listStep = 1;
        step("step_in_idle", 8'h00, 8'h00, 0, 0, 3'd0, 0);

        // Empty mask: no RUN, immediate done pulse.
        listStart = 1; listMask = 8'h00;
        step("empty_mask", 8'h00, 8'h00, 0, 0, 3'd0, 1);
        step("empty_after", 8'h00, 8'h00, 0, 0, 3'd0, 0);

        // Reset mid-RUN with regOes = 8'h10.
        listStart = 1; listMask = 8'h10;
        step("rst_walk_start", 8'h00, 8'h00, 0, 1, 3'd4, 0);
        oe = 1;
        step("rst_walk_oe", 8'h10, 8'h00, 0, 1, 3'd4, 0);
        #2;
        notReset = 0;
        #1;
        z = '{"async_reset", 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0};
        check_all(z);
        @(negedge clock);
        notReset = 1;
        // Fields were cleared: operand 0 now selects register 0.
        oe = 1; oeSourceSel = 2'd1; load = 1; useqRegSelLoad = 3'd6;
        step("post_reset", 8'h01, 8'h40, 0, 0, 3'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_sel_seq.md
REG_SEL_SEQ -- requirements
Module: reg_sel_seq

Interface
REQ-001 SHALL have parameter NREGS, default 8, number of registers; power of two, 4..32.
REQ-002 SHALL have parameter NOPS, default 3, number of instruction operand fields, 1..7.
REQ-003 SHALL derive SELW = clog2(NREGS) and SSW = clog2(NOPS+1); neither is user-settable.
REQ-004 SHALL have port clock  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port notReset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port irLoad  input  1  latch opFields this cycle.
REQ-007 SHALL have port opFields  input  NOPS*SELW  operand fields; field k at bits [k*SELW +: SELW].
REQ-008 SHALL have port oe  input  1  request output-enable strobe.
REQ-009 SHALL have port load  input  1  request load strobe.
REQ-010 SHALL have port oeSourceSel  input  SSW  0 = sequencer/list, k = operand field k-1.
REQ-011 SHALL have port loadSourceSel  input  1  0 = sequencer/list, 1 = operand field 0.
REQ-012 SHALL have ports useqRegSelOe, useqRegSelLoad  input  SELW each  microsequencer register indices.
REQ-013 SHALL have port listStart  input  1  start register-list walk.
REQ-014 SHALL have port listMask  input  NREGS  registers to walk, bit i = register i.
REQ-015 SHALL have port listDir  input  1  0 = ascending, 1 = descending; sampled with listStart.
REQ-016 SHALL have port listStep  input  1  current list register consumed, advance.
REQ-017 SHALL have port regOes  output  NREGS  registered one-hot (or zero) output enables.
REQ-018 SHALL have port regLoads  output  NREGS  registered one-hot (or zero) load strobes.
REQ-019 SHALL have port listBusy  output  1  high while in RUN.
REQ-020 SHALL have port listCur  output  SELW  current list register index; 0 when IDLE.
REQ-021 SHALL have port listDone  output  1  one-cycle pulse at list completion.
REQ-022 SHALL have port sameReg  output  1  registered flag: regOes and regLoads both nonzero and equal.

Function
REQ-023 SHALL latch opFields into internal field registers on any clock edge with irLoad=1; selection in that same cycle uses the previously latched values.
REQ-024 SHALL register regOes/regLoads: inputs in cycle N appear in cycle N+1; no combinational path input->output.
REQ-025 SHALL drive regOes = 1<<idx when oe=1, idx from oeSourceSel; zero when oe=0 or oeSourceSel>NOPS.
REQ-026 SHALL drive regLoads = 1<<idx when load=1, idx from loadSourceSel; zero when load=0.
REQ-027 SHALL, for source 0, use listCur while listBusy=1, else useqRegSelOe/useqRegSelLoad respectively.
REQ-028 SHALL register sameReg with the same one-cycle latency as regOes/regLoads, computed from the next-state strobes.
REQ-029 SHALL implement FSM states IDLE and RUN.
REQ-030 SHALL, in IDLE with listStart=1 and listMask!=0, load pending=listMask, capture listDir, enter RUN next cycle.
REQ-031 SHALL, in IDLE with listStart=1 and listMask=0, stay IDLE and pulse listDone next cycle.
REQ-032 SHALL in RUN set listCur = lowest set bit of pending (dir 0) or highest (dir 1), combinationally from pending.
REQ-033 SHALL in RUN with listStep=1 clear bit listCur from pending; if pending becomes zero, enter IDLE and pulse listDone in the same edge.
REQ-034 SHALL ignore listStart in RUN and listStep in IDLE; simultaneous listStart+listStep in IDLE: start wins, step dropped.
REQ-035 SHALL select the list register for the cycle's strobe before applying listStep (strobe uses pre-step listCur).

Reset
REQ-036 SHALL, on notReset=0, asynchronously clear regOes, regLoads, sameReg, listDone, field registers, pending, direction; FSM to IDLE, listBusy=0, listCur=0.
REQ-037 SHALL abort any list walk on reset without a listDone pulse; first strobe after release reflects inputs sampled at first edge.

Verification (NREGS=8, NOPS=3)
REQ-038 SHALL test: irLoad with fields {2,5,7} (op0=7,op1=5,op2=2), next cycle oe=1 oeSourceSel=2 -> regOes=8'h20 one cycle later.
REQ-039 SHALL test: oe=1 oeSourceSel=1, load=1 loadSourceSel=1, op0=7 -> regOes=regLoads=8'h80, sameReg=1.
REQ-040 SHALL test: listStart mask=8'b1001_0010 dir=0, listStep each cycle with oe=1 src 0 -> regOes 8'h02,8'h10,8'h80; listDone pulse on 3rd step; listBusy low after.
REQ-041 SHALL test: same mask dir=1 -> listCur 7,4,1; listStart mid-RUN ignored.
REQ-042 SHALL test: listStart mask=0 -> listBusy stays 0, listDone pulses next cycle; oeSourceSel=3'd4 (out of range, SSW=2 so use NOPS=3, sel=... n/a) skipped; oe=0 -> regOes=0.
REQ-043 SHALL test: notReset low mid-RUN with regOes=8'h10 -> all outputs 0 immediately, no listDone, listCur=0.
